// File: rtl/m_dist5.sv
// Five-way destination distributor: words enter a small circular FIFO and the head is
// steered to the source port named by its 3-bit dest; dests 5..7 are discarded and counted.
`ifndef WORD_BITS
`define WORD_BITS 32
`endif

module m_dist5 #(
    parameter int p_st_bits = `WORD_BITS,
    parameter int p_depth   = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [p_st_bits-1:0]       iSnk0Data,
    input  logic [2:0]                 iSnk0Dest,
    input  logic                       iSnk0Valid,
    output logic                       oSnk0Ready,
    output logic [p_st_bits-1:0]       oSrc0Data,
    output logic [p_st_bits-1:0]       oSrc1Data,
    output logic [p_st_bits-1:0]       oSrc2Data,
    output logic [p_st_bits-1:0]       oSrc3Data,
    output logic [p_st_bits-1:0]       oSrc4Data,
    output logic                       oSrc0Valid,
    output logic                       oSrc1Valid,
    output logic                       oSrc2Valid,
    output logic                       oSrc3Valid,
    output logic                       oSrc4Valid,
    input  logic                       iSrc0Ready,
    input  logic                       iSrc1Ready,
    input  logic                       iSrc2Ready,
    input  logic                       iSrc3Ready,
    input  logic                       iSrc4Ready,
    output logic [$clog2(p_depth):0]   oCount,
    output logic [7:0]                 oDropCnt
);

    localparam int c_aw = $clog2(p_depth);

    logic [p_st_bits-1:0] r_data [p_depth];
    logic [2:0]           r_dest [p_depth];
    logic [c_aw-1:0]      r_rd_ptr;
    logic [c_aw-1:0]      r_wr_ptr;
    logic [c_aw:0]        r_count;
    logic [7:0]           r_drop_cnt;

    logic [p_st_bits-1:0] w_head_data;
    logic [2:0]           w_head_dest;
    logic                 w_nonempty;
    logic                 w_illegal;
    logic [4:0]           w_valid;
    logic [4:0]           w_src_ready;
    logic                 w_push;
    logic                 w_pop;

    assign w_head_data = r_data[r_rd_ptr];
    assign w_head_dest = r_dest[r_rd_ptr];
    assign w_nonempty  = (r_count != '0);
    assign w_illegal   = w_nonempty && (w_head_dest > 3'd4);
    assign w_src_ready = {iSrc4Ready, iSrc3Ready, iSrc2Ready, iSrc1Ready, iSrc0Ready};

    always_comb begin
        w_valid = '0;
        for (int n = 0; n < 5; n++) begin
            w_valid[n] = w_nonempty && (w_head_dest == 3'(n));
        end
    end

    // Depth is a power of two, so the count MSB is set exactly when the FIFO is full.
    assign oSnk0Ready = ~r_count[c_aw];
    assign w_push     = iSnk0Valid && oSnk0Ready;
    assign w_pop      = w_illegal || (|(w_valid & w_src_ready));

    assign oSrc0Valid = w_valid[0];
    assign oSrc1Valid = w_valid[1];
    assign oSrc2Valid = w_valid[2];
    assign oSrc3Valid = w_valid[3];
    assign oSrc4Valid = w_valid[4];
    assign oSrc0Data  = w_valid[0] ? w_head_data : '0;
    assign oSrc1Data  = w_valid[1] ? w_head_data : '0;
    assign oSrc2Data  = w_valid[2] ? w_head_data : '0;
    assign oSrc3Data  = w_valid[3] ? w_head_data : '0;
    assign oSrc4Data  = w_valid[4] ? w_head_data : '0;
    assign oCount     = r_count;
    assign oDropCnt   = r_drop_cnt;

    // Storage needs no reset: an empty count hides stale entries.
    always_ff @(posedge clk) begin
        if (w_push && rst) begin
            r_data[r_wr_ptr] <= iSnk0Data;
            r_dest[r_wr_ptr] <= iSnk0Dest;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_drop_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_illegal && (r_drop_cnt != 8'hFF)) begin
                r_drop_cnt <= r_drop_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_m_dist5.sv
// Bench for m_dist5: directed scenarios followed by random traffic, all checked against a
// queue-based model of the distributor.
module tb_m_dist5;

    localparam int W     = 16;
    localparam int DEPTH = 4;

    typedef struct {
        logic [2:0]   dest;
        logic [W-1:0] data;
    } ent_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [W-1:0] snk_data = '0;
    logic [2:0]   snk_dest = '0;
    logic         snk_valid = 1'b0;
    logic         snk_ready;
    logic [4:0]   rdy = '0;
    logic [4:0]   src_valid;
    logic [W-1:0] src_data [5];
    logic [2:0]   count;
    logic [7:0]   drop_cnt;

    ent_t exp_q[$];
    int   exp_drops = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    m_dist5 #(.p_st_bits(W), .p_depth(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .iSnk0Data(snk_data), .iSnk0Dest(snk_dest), .iSnk0Valid(snk_valid), .oSnk0Ready(snk_ready),
        .oSrc0Data(src_data[0]), .oSrc1Data(src_data[1]), .oSrc2Data(src_data[2]),
        .oSrc3Data(src_data[3]), .oSrc4Data(src_data[4]),
        .oSrc0Valid(src_valid[0]), .oSrc1Valid(src_valid[1]), .oSrc2Valid(src_valid[2]),
        .oSrc3Valid(src_valid[3]), .oSrc4Valid(src_valid[4]),
        .iSrc0Ready(rdy[0]), .iSrc1Ready(rdy[1]), .iSrc2Ready(rdy[2]),
        .iSrc3Ready(rdy[3]), .iSrc4Ready(rdy[4]),
        .oCount(count), .oDropCnt(drop_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected outputs derive only from the model queue head and the drop total.
    task automatic check_model(input string tag);
        logic [4:0] ev;
        ev = '0;
        if (exp_q.size() > 0 && exp_q[0].dest < 3'd5) ev[exp_q[0].dest] = 1'b1;
        chk({tag, "_count"}, 32'(count), 32'(exp_q.size()));
        chk({tag, "_ready"}, 32'(snk_ready), 32'(exp_q.size() < DEPTH));
        chk({tag, "_drops"}, 32'(drop_cnt), 32'(exp_drops));
        chk({tag, "_valid"}, 32'(src_valid), 32'(ev));
        for (int n = 0; n < 5; n++) begin
            chk($sformatf("%s_data%0d", tag, n), 32'(src_data[n]),
                ev[n] ? 32'(exp_q[0].data) : 32'd0);
        end
    endtask

    task automatic tick(input string tag);
        bit   do_push, do_pop, is_drop;
        ent_t e;
        #1;
        check_model(tag);
        do_push = snk_valid && (exp_q.size() < DEPTH);
        do_pop  = (exp_q.size() > 0) && ((exp_q[0].dest > 3'd4) || rdy[exp_q[0].dest]);
        is_drop = do_pop && (exp_q[0].dest > 3'd4);
        e.dest  = snk_dest;
        e.data  = snk_data;
        @(posedge clk);
        #1;
        if (do_pop) begin
            if (is_drop && exp_drops < 255) exp_drops++;
            void'(exp_q.pop_front());
        end
        if (do_push) exp_q.push_back(e);
    endtask

    task automatic drive(input bit v, input logic [2:0] d, input logic [W-1:0] x);
        snk_valid = v;
        snk_dest  = d;
        snk_data  = x;
    endtask

    initial begin
        // Reset at time zero.
        #1;
        check_model("reset0");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Single word to dest 2 with its ready high.
        rdy = 5'b00100;
        drive(1, 3'd2, 16'h0011);
        tick("r030_a");
        drive(0, 3'd0, '0);
        chk("r030_valid", 32'(src_valid), 32'h04);
        chk("r030_data", 32'(src_data[2]), 32'h11);
        tick("r030_b");
        chk("r030_empty", 32'(count), 32'd0);

        // Fill with all readies low; fifth word is held off.
        rdy = '0;
        for (int i = 0; i < 5; i++) begin
            drive(1, 3'd0, W'(16'h0100 + i));
            tick("r031_fill");
        end
        chk("r031_count", 32'(count), 32'd4);
        chk("r031_ready", 32'(snk_ready), 32'd0);
        drive(0, 3'd0, '0);
        rdy = 5'b11111;
        for (int i = 0; i < 5; i++) tick("r031_drain");

        // Illegal dest followed by a legal one.
        drive(1, 3'd7, 16'h00EE);
        tick("r032_a");
        drive(1, 3'd1, 16'h0022);
        tick("r032_b");
        drive(0, 3'd0, '0);
        chk("r032_drops", 32'(drop_cnt), 32'd1);
        chk("r032_data", 32'(src_data[1]), 32'h22);
        tick("r032_c");

        // Head-of-line blocking on dest 3.
        rdy = 5'b10111;
        drive(1, 3'd3, 16'h0333);
        tick("r033_a");
        drive(1, 3'd0, 16'h0444);
        tick("r033_b");
        drive(0, 3'd0, '0);
        for (int i = 0; i < 3; i++) begin
            tick("r033_hold");
            chk("r033_count", 32'(count), 32'd2);
        end
        rdy = 5'b11111;
        for (int i = 0; i < 3; i++) tick("r033_release");

        // Streaming with wrap; occupancy stays at one.
        for (int i = 0; i < 10; i++) begin
            drive(1, 3'(i % 5), W'(16'h0500 + i));
            tick("r034_stream");
            chk("r034_count", 32'(count), 32'd1);
        end
        drive(0, 3'd0, '0);
        tick("r034_tail");
        tick("r034_empty");

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), W'($urandom));
            rdy = 5'($urandom_range(0, 31));
            tick("rand");
        end
        drive(0, 3'd0, '0);
        rdy = 5'b11111;
        for (int i = 0; i < 6; i++) tick("rand_drain");

        // Drop counter saturation.
        for (int i = 0; i < 260; i++) begin
            drive(1, 3'($urandom_range(5, 7)), W'($urandom));
            tick("sat");
        end
        drive(0, 3'd0, '0);
        tick("sat_tail");
        tick("sat_idle");
        chk("sat_drops", 32'(drop_cnt), 32'd255);

        // Asynchronous reset mid-cycle with three words held.
        rdy = '0;
        for (int i = 0; i < 3; i++) begin
            drive(1, 3'(i + 1), W'(16'h0700 + i));
            tick("r035_fill");
        end
        drive(0, 3'd0, '0);
        chk("r035_pre_count", 32'(count), 32'd3);
        #2;
        rst = 1'b0;
        #1;
        chk("r035_count", 32'(count), 32'd0);
        chk("r035_ready", 32'(snk_ready), 32'd1);
        chk("r035_drops", 32'(drop_cnt), 32'd0);
        chk("r035_valid", 32'(src_valid), 32'd0);
        for (int n = 0; n < 5; n++) chk($sformatf("r035_data%0d", n), 32'(src_data[n]), 32'd0);
        exp_q.delete();
        exp_drops = 0;
        rdy = 5'b11111;
        drive(1, 3'd0, 16'h0999);
        @(posedge clk);
        #1;
        chk("r029_count", 32'(count), 32'd0);
        rst = 1'b1;
        drive(0, 3'd0, '0);
        for (int i = 0; i < 3; i++) tick("r035_after");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
